// File: rtl/busca_instrucao.sv
// Instruction fetch stage: requests words from instruction memory, hands them to decode
// with a valid/ready handshake and follows branch redirects. Optional macro: BUSCA_FETCH_COUNT_EN.
module busca_instrucao #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  state_dbg
`ifdef BUSCA_FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  // Handshake: decode takes the instruction on any rising edge where
  // instr_valid=1 and instr_ready=1; instruction/pc_out are frozen until then.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] drain_addr, drain_addr_next;
  logic        load_instr;
  logic        transfer;

  assign transfer  = instr_valid && instr_ready;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drain_addr  <= 32'h0;
      instruction <= 32'h0;
      pc_out      <= 32'h0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      drain_addr <= drain_addr_next;
      if (load_instr) begin
        instruction <= mem_rdata;
        pc_out      <= pc;
      end
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    drain_addr_next = drain_addr;
    load_instr      = 1'b0;
    mem_req         = 1'b0;
    mem_addr        = 32'h0;
    instr_valid     = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
        if (redirect) pc_next = {redirect_pc[31:2], 2'b00};
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (redirect) begin
          pc_next = {redirect_pc[31:2], 2'b00};
          // An unanswered request must still be retired before fetching the target.
          if (!mem_ack) begin
            drain_addr_next = pc;
            state_next      = DRAIN;
          end
        end else if (mem_ack) begin
          load_instr = 1'b1;
          pc_next    = pc + 32'd4;
          state_next = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (redirect) begin
          pc_next    = {redirect_pc[31:2], 2'b00};
          state_next = REQ;
        end else if (instr_ready) begin
          state_next = REQ;
        end
      end
      DRAIN: begin
        mem_req  = 1'b1;
        mem_addr = drain_addr;
        if (redirect) pc_next = {redirect_pc[31:2], 2'b00};
        if (mem_ack) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BUSCA_FETCH_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_count <= 32'h0;
    else if (transfer) fetch_count <= fetch_count + 32'd1;
  end
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: reset, zero-wait and delayed fetch, back-pressure,
// redirects in every state, pc wrap and asynchronous reset mid-request.
module tb_busca_instrucao;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  state_dbg;
`ifdef BUSCA_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2, S_DRAIN = 2'd3;

  always #5 clk = ~clk;

  busca_instrucao #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .instruction(instruction),
    .pc_out(pc_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .state_dbg(state_dbg)
`ifdef BUSCA_FETCH_COUNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_mem_addr"}, mem_addr, addr);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic chk_hold(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_instr"}, instruction, ins);
    chk({tag, "_pc_out"}, pc_out, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});

    // Zero-wait fetch at address 0
    rst = 1'b0;
    tick();
    chk_req("zw_req", 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1807_0000;
    tick();
    mem_ack = 1'b0;
    chk_hold("zw_hold", 32'h1807_0000, 32'h0);
    tick();
    chk_req("zw_next", 32'h4);

    // Ack delayed 3 cycles at address 4
    for (int i = 0; i < 3; i++) begin
      chk_req("wait_req", 32'h4);
      tick();
    end
    chk_req("wait_ack", 32'h4);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0004;
    tick();
    mem_ack = 1'b0;
    chk_hold("wait_hold", 32'hA5A5_0004, 32'h4);

    // Back-pressure: 5 cycles not ready, transfer on the 6th
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_hold("bp_hold", 32'hA5A5_0004, 32'h4);
      tick();
    end
    instr_ready = 1'b1;
    chk_hold("bp_last", 32'hA5A5_0004, 32'h4);
    tick();
    chk_req("bp_next", 32'h8);

    // Redirect in REQ without ack -> DRAIN, old response discarded
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    chk("drain_state", {30'd0, state_dbg}, {30'd0, S_DRAIN});
    chk_req("drain1", 32'h8);
    tick();
    chk_req("drain2", 32'h8);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk_req("drain_done", 32'h100);
    chk("drain_discard", instruction, 32'hA5A5_0004);
    mem_rdata = 32'h1111_0100;
    tick();
    mem_ack = 1'b0;
    chk_hold("tgt_hold", 32'h1111_0100, 32'h100);
    tick();
    chk_req("tgt_next", 32'h104);

    // Redirect in REQ with ack -> data discarded, stay in REQ at new pc
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
    tick();
    redirect = 1'b0;
    chk_req("rdack_req", 32'hFFFF_FFFC);
    chk("rdack_discard", instruction, 32'h1111_0100);
    mem_rdata = 32'h2222_0000;
    tick();
    mem_ack = 1'b0;
    chk_hold("top_hold", 32'h2222_0000, 32'hFFFF_FFFC);
    tick();
    chk_req("wrap_req", 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h3333_0000;
    tick();
    mem_ack = 1'b0;
    chk_hold("wrap_hold", 32'h3333_0000, 32'h0);
`ifdef BUSCA_FETCH_COUNT_EN
    chk("fetch_count", fetch_count, 32'd4);
`endif

    // Redirect in HOLD (not ready): low bits forced to zero
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    redirect = 1'b0; instr_ready = 1'b1;
    chk_req("hold_rd", 32'h40);

    // Redirect inside DRAIN only moves pc
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    chk_req("dr_a", 32'h40);
    tick();
    redirect = 1'b0;
    chk("dr_state", {30'd0, state_dbg}, {30'd0, S_DRAIN});
    chk_req("dr_b", 32'h40);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk_req("dr_done", 32'h300);

    // Asynchronous reset mid-request; ack during IDLE ignored
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
`ifdef BUSCA_FETCH_COUNT_EN
    chk("arst_count", fetch_count, 32'd0);
`endif
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h4444_0000;
    rst = 1'b0;
    chk("idle_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk_req("rs_req", 32'h0);
    tick();
    mem_ack = 1'b0;
    chk_hold("rs_hold", 32'h4444_0000, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: mem_req  output  1  instruction-memory read request.
REQ-005 Port: mem_addr  output  32  word-aligned read address, valid while mem_req=1.
REQ-006 Port: mem_ack  input  1  memory response strobe; mem_rdata valid in the same cycle.
REQ-007 Port: mem_rdata  input  32  fetched instruction word.
REQ-008 Port: instruction  output  32  instruction presented to the decode/control stage.
REQ-009 Port: pc_out  output  32  address of the presented instruction.
REQ-010 Port: instr_valid  output  1  instruction/pc_out are valid.
REQ-011 Port: instr_ready  input  1  downstream accepts; a transfer SHALL occur on any edge with instr_valid=1 and instr_ready=1.
REQ-012 Port: redirect, redirect_pc  input  1/32  branch/jump request and target address.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, REQ, HOLD and DRAIN.
REQ-014 IDLE: mem_req=0, instr_valid=0; SHALL move to REQ on the first edge after reset release.
REQ-015 REQ: mem_req=1, mem_addr=pc; on an edge with mem_ack=1 it SHALL load instruction<=mem_rdata and pc_out<=pc, set pc<=pc+4 (mod 2^32, wraps), set instr_valid=1 and move to HOLD.
REQ-016 mem_ack in the first REQ cycle SHALL be accepted (zero-wait memory); mem_req SHALL never drop before mem_ack.
REQ-017 HOLD: mem_req=0, instr_valid=1, instruction and pc_out SHALL stay stable until transfer; on transfer the block SHALL return to REQ.
REQ-018 Throughput SHALL be at most one instruction per 2 cycles; latency from REQ entry with zero-wait ack to instr_valid=1 SHALL be 1 cycle.
REQ-019 redirect SHALL have highest priority; pc<=redirect_pc with bits [1:0] forced to 0.
REQ-020 redirect in HOLD SHALL clear instr_valid and go to REQ; redirect coinciding with a transfer SHALL count the transfer as done and still redirect.
REQ-021 redirect in REQ with mem_ack=1 SHALL discard mem_rdata, keep instr_valid=0 and stay in REQ at the new pc.
REQ-022 redirect in REQ with mem_ack=0 SHALL go to DRAIN: mem_req stays 1 with the old mem_addr until mem_ack, response discarded, then REQ at the new pc.
REQ-023 redirect in DRAIN SHALL update pc only and remain in DRAIN.
REQ-024 instr_valid SHALL be 0 in IDLE, REQ and DRAIN.

Reset
REQ-025 On rst=1, regardless of clk, the block SHALL set state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0, instruction=0, pc_out=0, instr_valid=0.
REQ-026 Reset mid-request SHALL drop mem_req immediately; a later mem_ack while in IDLE SHALL be ignored.

Configuration
REQ-027 With macro BUSCA_FETCH_COUNT_EN defined, the block SHALL add output fetch_count [31:0], reset to 0, incremented by 1 on each transfer, wrapping at 2^32.
REQ-028 Without BUSCA_FETCH_COUNT_EN the port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-029 Reset release, zero-wait memory returning 32'h18070000 at addr 0, instr_ready=1 -> mem_addr=0, instruction=32'h18070000, pc_out=0, next mem_addr=4.
REQ-030 mem_ack delayed 3 cycles at addr 4 -> mem_req held 3+ cycles with mem_addr=4, instr_valid rises the cycle after ack.
REQ-031 instr_ready=0 for 5 cycles in HOLD -> instruction/pc_out stable, mem_req=0; transfer on 6th cycle.
REQ-032 redirect to 32'h0000_0102 during REQ with ack pending 2 cycles -> DRAIN, old response discarded, next mem_addr=32'h0000_0100.
REQ-033 pc=32'hFFFF_FFFC fetch -> next mem_addr=0; with BUSCA_FETCH_COUNT_EN, fetch_count increments by 1 per transfer from 0.
REQ-034 rst asserted mid-REQ -> mem_req=0 immediately; after release fetch restarts at RESET_PC.
